// File: rtl/normaliser_iter.sv
// Iterative left-normaliser: scans STEP bits per cycle for the leading one,
// then reports the normalised word, shift amount and original lead position.
module normaliser_iter #(
    parameter int DATA_W = 50,
    parameter int STEP   = 8,
    parameter int POS_W  = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [POS_W-1:0]  shift_amt,
    output logic [POS_W-1:0]  lead_pos,
    output logic              zero
);

    localparam int CW = POS_W + 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] work_q, work_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] od_q, od_d;
    logic [POS_W-1:0]  sh_q, sh_d;
    logic [POS_W-1:0]  lp_q, lp_d;
    logic              zero_q, zero_d;

    logic              found;
    logic [CW-1:0]     k;
    logic [CW-1:0]     cnt_k;
    logic [CW-1:0]     cnt_s;

    // Lowest offset from the MSB wins, so scan from the bottom of the window up.
    always_comb begin
        found = 1'b0;
        k     = '0;
        for (int i = STEP - 1; i >= 0; i--) begin
            if (work_q[DATA_W-1-i]) begin
                found = 1'b1;
                k     = CW'(i);
            end
        end
        cnt_k = cnt_q + k;
        cnt_s = cnt_q + CW'(STEP);
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        od_d    = od_q;
        sh_d    = sh_q;
        lp_d    = lp_q;
        zero_d  = zero_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d = in_data;
                    cnt_d  = '0;
                    if (in_data == '0) begin
                        state_d = DONE;
                        od_d    = '0;
                        sh_d    = '0;
                        lp_d    = '0;
                        zero_d  = 1'b1;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (found) begin
                    work_d  = work_q << k;
                    cnt_d   = cnt_k;
                    state_d = DONE;
                    od_d    = work_q << k;
                    sh_d    = POS_W'(cnt_k);
                    lp_d    = POS_W'(LAST - cnt_k);
                    zero_d  = 1'b0;
                end else begin
                    work_d = work_q << STEP;
                    cnt_d  = cnt_s;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            od_q    <= '0;
            sh_q    <= '0;
            lp_q    <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            od_q    <= od_d;
            sh_q    <= sh_d;
            lp_q    <= lp_d;
            zero_q  <= zero_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = od_q;
    assign shift_amt = sh_q;
    assign lead_pos  = lp_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_normaliser_iter.sv
// Bench for normaliser_iter: three 16-bit instances (STEP 1, 4, 16) checked
// against a leading-zero-count reference model with random and directed operands.
module tb_normaliser_iter;

    localparam int W = 16;
    localparam int PW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [2:0]             iv  = '0;
    logic [2:0]             ir;
    logic [2:0][W-1:0]      din = '0;
    logic [2:0]             ov;
    logic [2:0]             orr = '0;
    logic [2:0][W-1:0]      od;
    logic [2:0][PW-1:0]     sa;
    logic [2:0][PW-1:0]     lp;
    logic [2:0]             zr;

    int steps [3] = '{1, 4, 16};
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    normaliser_iter #(.DATA_W(W), .STEP(1)) u_s1 (
        .clk(clk), .rst(rst),
        .in_valid(iv[0]), .in_ready(ir[0]), .in_data(din[0]),
        .out_valid(ov[0]), .out_ready(orr[0]), .out_data(od[0]),
        .shift_amt(sa[0]), .lead_pos(lp[0]), .zero(zr[0])
    );

    normaliser_iter #(.DATA_W(W), .STEP(4)) u_s4 (
        .clk(clk), .rst(rst),
        .in_valid(iv[1]), .in_ready(ir[1]), .in_data(din[1]),
        .out_valid(ov[1]), .out_ready(orr[1]), .out_data(od[1]),
        .shift_amt(sa[1]), .lead_pos(lp[1]), .zero(zr[1])
    );

    normaliser_iter #(.DATA_W(W), .STEP(16)) u_s16 (
        .clk(clk), .rst(rst),
        .in_valid(iv[2]), .in_ready(ir[2]), .in_data(din[2]),
        .out_valid(ov[2]), .out_ready(orr[2]), .out_data(od[2]),
        .shift_amt(sa[2]), .lead_pos(lp[2]), .zero(zr[2])
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int lzc(input logic [W-1:0] v);
        for (int i = W - 1; i >= 0; i--)
            if (v[i]) return W - 1 - i;
        return W;
    endfunction

    // Latency is counted in edges after the accept edge; a zero operand
    // lands in DONE on the accept edge itself.
    task automatic run_op(input int u, input logic [W-1:0] d, input int hold);
        int lz;
        bit z;
        logic [W-1:0] e_out;
        int e_sh, e_lp, e_lat, lat;
        lz    = lzc(d);
        z     = (d == '0);
        e_out = z ? '0 : W'(d << lz);
        e_sh  = z ? 0 : lz;
        e_lp  = z ? 0 : W - 1 - lz;
        e_lat = z ? 0 : lz / steps[u] + 1;

        @(negedge clk);
        check("in_ready_idle", 32'(ir[u]), 32'd1);
        iv[u]  = 1'b1;
        din[u] = d;
        @(posedge clk);
        #1;
        iv[u]  = 1'b0;
        din[u] = W'($urandom);
        lat = 0;
        while (!ov[u] && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(e_lat));
        check("out_data", 32'(od[u]), 32'(e_out));
        check("shift_amt", 32'(sa[u]), 32'(e_sh));
        check("lead_pos", 32'(lp[u]), 32'(e_lp));
        check("zero", 32'(zr[u]), 32'(z));

        for (int h = 0; h < hold; h++) begin
            if (h == 1) begin
                iv[u]  = 1'b1;
                din[u] = 16'h0001;
            end
            @(posedge clk);
            #1;
            check("hold_valid", 32'(ov[u]), 32'd1);
            check("hold_ready", 32'(ir[u]), 32'd0);
            check("hold_data", 32'(od[u]), 32'(e_out));
            check("hold_shift", 32'(sa[u]), 32'(e_sh));
            check("hold_lead", 32'(lp[u]), 32'(e_lp));
        end
        iv[u] = 1'b0;

        orr[u] = 1'b1;
        @(posedge clk);
        #1;
        orr[u] = 1'b0;
        check("post_valid", 32'(ov[u]), 32'd0);
        check("post_ready", 32'(ir[u]), 32'd1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        for (int u = 0; u < 3; u++) begin
            check("rst_valid", 32'(ov[u]), 32'd0);
            check("rst_ready", 32'(ir[u]), 32'd1);
            check("rst_data", 32'(od[u]), 32'd0);
            check("rst_shift", 32'(sa[u]), 32'd0);
            check("rst_lead", 32'(lp[u]), 32'd0);
            check("rst_zero", 32'(zr[u]), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        run_op(1, 16'h0001, 0);
        run_op(1, 16'h8000, 0);
        run_op(1, 16'h00F0, 0);
        run_op(1, 16'h0000, 0);
        run_op(1, 16'h0300, 5);

        // Reset while u_s4 is mid-scan on 0x0001.
        @(negedge clk);
        iv[1]  = 1'b1;
        din[1] = 16'h0001;
        @(posedge clk);
        #1;
        iv[1] = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_valid", 32'(ov[1]), 32'd0);
        check("midrst_ready", 32'(ir[1]), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            check("midrst_noout", 32'(ov[1]), 32'd0);
        end

        for (int u = 0; u < 3; u++) begin
            run_op(u, 16'hFFFF, 0);
            run_op(u, 16'h0001, 0);
            run_op(u, 16'h0000, 1);
            for (int n = 0; n < 150; n++) begin
                logic [W-1:0] d;
                d = W'($urandom_range(0, 65535) >> $urandom_range(0, 16));
                run_op(u, d, ($urandom_range(0, 7) == 0) ? 3 : 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
